// File: rtl/pmcc_instr_fetch.sv
// Purpose: PMCC instruction fetch; drives code DPRAM port B and queues fetched words with their PC for the decoder.
// Latency: start/jump sampled in cycle 0 -> mem_addr cycle 1 -> rdata cycle 2 -> instr_valid cycle 3; then 1 instr/cycle.
// Backpressure: instr_valid/instr_ready handshake; fetch stalls (mem_addr held, no tag issued) when buffer + in-flight is full.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   start, start_pc           pulse: begin fetching at start_pc (in RUN: acts as a jump)
//   stop                      pulse: abort fetch, flush, return to IDLE
//   jump, jump_target         pulse: redirect fetch while in RUN (ignored in IDLE)
//   mem_addr, mem_rdata       DPRAM port B address / read data (data valid 1 cycle after address)
//   instr, instr_pc           head of instruction buffer and its byte address
//   instr_valid, instr_ready  decoder handshake; pop on instr_valid & instr_ready
//   busy                      high while in RUN
module pmcc_instr_fetch #(
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned BUF_DEPTH = 4,
    parameter logic [31:0] RESET_PC  = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] start_pc,
    input  logic        stop,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW - 2;
    localparam int BW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam logic [CW:0]   BUF_LIM  = (CW + 1)'(BUF_DEPTH);
    localparam logic [BW-1:0] PTR_LAST = BW'(BUF_DEPTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state;

    // Word index of the address currently on mem_addr (the last issued fetch).
    logic [PW-1:0] pc_q;

    // In-flight tags: a_vld marks the RAM address stage (address on mem_addr
    // this cycle was issued), d_vld/d_pc mark the RAM data stage.
    logic          a_vld;
    logic          d_vld;
    logic [PW-1:0] d_pc;

    logic [31:0]   buf_dat [BUF_DEPTH];
    logic [PW-1:0] buf_pc  [BUF_DEPTH];
    logic [BW-1:0] rd_ptr;
    logic [BW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic          pop;
    logic          push;
    logic          redirect;
    logic          halt;
    logic          flush;
    logic [PW-1:0] redirect_pc;
    logic [CW:0]   occ;

    // Byte offset and upper address bits are meaningless inside the code memory.
    logic unused_bits;
    assign unused_bits = ^{start_pc[31:AW], start_pc[1:0], jump_target[31:AW], jump_target[1:0]};

    assign pop      = instr_valid & instr_ready;
    assign redirect = (state == RUN) & ~stop & (jump | start);
    assign halt     = (state == RUN) & stop;
    assign flush    = redirect | halt;
    // A word arriving on the same edge as a flush belongs to the old stream.
    assign push     = d_vld & ~flush;

    // Jump wins over a simultaneous start.
    assign redirect_pc = jump ? jump_target[AW-1:2] : start_pc[AW-1:2];

    // Slots already claimed after this edge's pop; issuing only below the limit
    // guarantees every in-flight word has a buffer slot when it lands.
    assign occ = (CW + 1)'(count) + (CW + 1)'(a_vld) + (CW + 1)'(d_vld) - (CW + 1)'(pop);

    assign mem_addr    = {{(32 - AW){1'b0}}, pc_q, 2'b00};
    assign instr       = buf_dat[rd_ptr];
    assign instr_pc    = {{(32 - AW){1'b0}}, buf_pc[rd_ptr], 2'b00};
    assign instr_valid = (count != '0);
    assign busy        = (state == RUN);

    function automatic logic [BW-1:0] next_ptr(input logic [BW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + BW'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            pc_q   <= RESET_PC[AW-1:2];
            a_vld  <= 1'b0;
            d_vld  <= 1'b0;
            d_pc   <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_dat[i] <= '0;
                buf_pc[i]  <= '0;
            end
        end else begin
            d_vld <= a_vld & ~flush;
            d_pc  <= pc_q;
            a_vld <= 1'b0;

            if (state == IDLE) begin
                if (start && !stop) begin
                    state <= RUN;
                    pc_q  <= start_pc[AW-1:2];
                    a_vld <= 1'b1;
                end
            end else begin
                if (stop) begin
                    state <= IDLE;
                end else if (jump || start) begin
                    pc_q  <= redirect_pc;
                    a_vld <= 1'b1;
                end else if (occ < BUF_LIM) begin
                    // Word index width makes DEPTH-4 -> 0 wrap automatic.
                    pc_q  <= pc_q + PW'(1);
                    a_vld <= 1'b1;
                end
            end

            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    buf_dat[wr_ptr] <= mem_rdata;
                    buf_pc[wr_ptr]  <= d_pc;
                    wr_ptr          <= next_ptr(wr_ptr);
                end
                if (pop) begin
                    rd_ptr <= next_ptr(rd_ptr);
                end
                if (push && !pop) begin
                    count <= count + CW'(1);
                end else if (pop && !push) begin
                    count <= count - CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_pmcc_instr_fetch.sv
// Bench for pmcc_instr_fetch: DPRAM port B model plus a queue of expected PCs,
// pushed when fetch stimulus is driven and popped on every decoder handshake.
module tb_pmcc_instr_fetch;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] start_pc;
    logic        stop;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        busy;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] sb [$];
    logic [31:0] code_mem [64];

    pmcc_instr_fetch #(
        .DEPTH    (256),
        .BUF_DEPTH(4),
        .RESET_PC (32'h0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_pc   (start_pc),
        .stop       (stop),
        .jump       (jump),
        .jump_target(jump_target),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Code DPRAM port B: registered read, one cycle latency.
    always @(posedge clk) mem_rdata <= code_mem[mem_addr[7:2]];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] word_of(input logic [31:0] pc);
        return {8'hA5, pc[7:0], ~pc[7:0], 8'h3C};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Runs one clock cycle: drives ready, scores a handshake if one occurs,
    // then returns #1 after the next rising edge with the pulses cleared.
    task automatic cycle_step(input logic rdy);
        logic [31:0] e;
        instr_ready = rdy;
        if (instr_valid === 1'b1 && rdy) begin
            n_cmp++;
            assert (sb.size() != 0)
            else begin
                n_err++;
                $error("FAIL unexpected_pop: observed pc %h expected no delivery", instr_pc);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("pop_pc", instr_pc, e);
                chk("pop_instr", instr, word_of(e));
            end
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
        jump  = 1'b0;
    endtask

    task automatic expect_pop();
        chk("pop_valid", {31'b0, instr_valid}, 32'd1);
        chk("addr_hi", {8'b0, mem_addr[31:8]}, 32'd0);
        cycle_step(1'b1);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_addr"}, mem_addr, 32'h0);
        chk({tag, "_instr"}, instr, 32'h0);
        chk({tag, "_pc"}, instr_pc, 32'h0);
        chk({tag, "_valid"}, {31'b0, instr_valid}, 32'd0);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
    endtask

    task automatic do_stop();
        stop = 1'b1;
        cycle_step(1'b0);
        chk("stop_busy", {31'b0, busy}, 32'd0);
        chk("stop_valid", {31'b0, instr_valid}, 32'd0);
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        stop        = 1'b0;
        jump        = 1'b0;
        start_pc    = 32'h0;
        jump_target = 32'h0;
        instr_ready = 1'b0;
        for (int i = 0; i < 64; i++) code_mem[i] = word_of(32'(i * 4));

        repeat (2) @(posedge clk);
        #1;
        check_reset("rst0");
        rst = 1'b0;

        // 1: basic start, 3-cycle latency, back-to-back delivery.
        start_pc = 32'h10;
        start    = 1'b1;
        sb.push_back(32'h10);
        sb.push_back(32'h14);
        sb.push_back(32'h18);
        cycle_step(1'b1);
        chk("t1_addr", mem_addr, 32'h10);
        chk("t1_busy", {31'b0, busy}, 32'd1);
        chk("t1_valid_c1", {31'b0, instr_valid}, 32'd0);
        cycle_step(1'b1);
        chk("t1_valid_c2", {31'b0, instr_valid}, 32'd0);
        cycle_step(1'b1);
        repeat (3) expect_pop();
        chk("t1_drain", sb.size(), 32'd0);
        do_stop();

        // 2: wrap from the top of the code memory.
        start_pc = 32'hF8;
        start    = 1'b1;
        sb.push_back(32'hF8);
        sb.push_back(32'hFC);
        sb.push_back(32'h00);
        sb.push_back(32'h04);
        cycle_step(1'b1);
        chk("t2_addr", mem_addr, 32'hF8);
        cycle_step(1'b1);
        cycle_step(1'b1);
        repeat (4) expect_pop();
        chk("t2_drain", sb.size(), 32'd0);
        do_stop();

        // 3: ready low for 10 cycles mid-run.
        start_pc = 32'h00;
        start    = 1'b1;
        for (int i = 0; i < 9; i++) sb.push_back(32'(i * 4));
        repeat (3) cycle_step(1'b1);
        repeat (2) expect_pop();
        for (int k = 0; k < 10; k++) begin
            chk("t3_valid", {31'b0, instr_valid}, 32'd1);
            chk("t3_frz_pc", instr_pc, sb[0]);
            chk("t3_frz_instr", instr, word_of(sb[0]));
            if (k >= 1) chk("t3_hold_addr", mem_addr, sb[0] + 32'd12);
            cycle_step(1'b0);
        end
        repeat (7) expect_pop();
        chk("t3_drain", sb.size(), 32'd0);
        do_stop();

        // 4: jump popping the instruction at 0x20, unaligned target.
        start_pc = 32'h18;
        start    = 1'b1;
        sb.push_back(32'h18);
        sb.push_back(32'h1C);
        sb.push_back(32'h20);
        repeat (3) cycle_step(1'b1);
        repeat (2) expect_pop();
        jump        = 1'b1;
        jump_target = 32'h43;
        sb.push_back(32'h40);
        sb.push_back(32'h44);
        expect_pop();
        chk("t4_valid_c1", {31'b0, instr_valid}, 32'd0);
        chk("t4_addr", mem_addr, 32'h40);
        cycle_step(1'b1);
        chk("t4_valid_c2", {31'b0, instr_valid}, 32'd0);
        cycle_step(1'b1);
        repeat (2) expect_pop();
        // start while running behaves as a redirect.
        start_pc = 32'h60;
        start    = 1'b1;
        sb.push_back(32'h60);
        cycle_step(1'b0);
        chk("t4s_valid_c1", {31'b0, instr_valid}, 32'd0);
        chk("t4s_busy", {31'b0, busy}, 32'd1);
        cycle_step(1'b1);
        chk("t4s_valid_c2", {31'b0, instr_valid}, 32'd0);
        cycle_step(1'b1);
        expect_pop();
        chk("t4_drain", sb.size(), 32'd0);
        do_stop();

        // 5: stop with words buffered and in flight.
        start_pc = 32'h00;
        start    = 1'b1;
        repeat (4) cycle_step(1'b0);
        chk("t5_buffered", {31'b0, instr_valid}, 32'd1);
        do_stop();
        chk("t5_addr_held", mem_addr, 32'h0C);
        repeat (3) begin
            cycle_step(1'b1);
            chk("t5_no_push", {31'b0, instr_valid}, 32'd0);
            chk("t5_addr_idle", mem_addr, 32'h0C);
        end
        // stop + jump in one cycle.
        start_pc = 32'h00;
        start    = 1'b1;
        repeat (2) cycle_step(1'b0);
        stop        = 1'b1;
        jump        = 1'b1;
        jump_target = 32'h80;
        cycle_step(1'b0);
        chk("t5_sj_busy", {31'b0, busy}, 32'd0);
        chk("t5_sj_addr", mem_addr, 32'h04);
        repeat (3) begin
            cycle_step(1'b1);
            chk("t5_sj_valid", {31'b0, instr_valid}, 32'd0);
        end
        // start + stop in IDLE.
        start_pc = 32'h40;
        start    = 1'b1;
        stop     = 1'b1;
        cycle_step(1'b1);
        chk("t5_ss_busy", {31'b0, busy}, 32'd0);
        chk("t5_ss_addr", mem_addr, 32'h04);
        repeat (2) begin
            cycle_step(1'b1);
            chk("t5_ss_valid", {31'b0, instr_valid}, 32'd0);
        end
        // jump in IDLE is ignored.
        jump        = 1'b1;
        jump_target = 32'h80;
        cycle_step(1'b1);
        chk("t5_ij_busy", {31'b0, busy}, 32'd0);
        chk("t5_ij_addr", mem_addr, 32'h04);
        cycle_step(1'b1);
        chk("t5_ij_valid", {31'b0, instr_valid}, 32'd0);

        // 6: asynchronous reset between edges, then clean restart.
        start_pc = 32'h00;
        start    = 1'b1;
        sb.push_back(32'h00);
        sb.push_back(32'h04);
        repeat (3) cycle_step(1'b1);
        repeat (2) expect_pop();
        #3;
        rst = 1'b1;
        #1;
        check_reset("rst_async");
        chk("t6_drain", sb.size(), 32'd0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        start_pc = 32'h00;
        start    = 1'b1;
        sb.push_back(32'h00);
        sb.push_back(32'h04);
        sb.push_back(32'h08);
        cycle_step(1'b1);
        chk("t6_addr", mem_addr, 32'h00);
        chk("t6_busy", {31'b0, busy}, 32'd1);
        cycle_step(1'b1);
        chk("t6_valid_c2", {31'b0, instr_valid}, 32'd0);
        cycle_step(1'b1);
        repeat (3) expect_pop();
        chk("t6_final_drain", sb.size(), 32'd0);
        do_stop();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
